fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL take parameter BITS, default 16, as the memory word and instruction width.
REQ-002 The block SHALL take parameter ADDR_W, default 8, as the memory address width (256 words).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; the port list follows.
REQ-004 i_clk  in  1  sole clock, all state on rising edge.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 o_mem_rw  out  1  memory write strobe; LOW read, HIGH write.
REQ-007 o_mem_addr  out  ADDR_W  memory address.
REQ-008 o_mem_data  out  BITS  memory write data.
REQ-009 i_mem_data  in  BITS  memory read data, combinational from o_mem_addr in the same cycle.
REQ-010 o_valid  out  1  instruction outputs valid.
REQ-011 i_ready  in  1  decode stage accepts the instruction.
REQ-012 o_op  out  7  opcode, instruction bits [15:9].
REQ-013 o_v  out  1  V flag, instruction bit [8].
REQ-014 o_imm  out  8  data field, instruction bits [7:0].
REQ-015 o_pc  out  ADDR_W  address the held instruction was fetched from.
REQ-016 i_jmp  in  1  redirect request, single-cycle.
REQ-017 i_jmp_addr  in  ADDR_W  redirect target.
REQ-018 i_dreq / i_dwe  in  1 / 1  data-access request / write-enable, from execute.
REQ-019 i_daddr / i_dwdata  in  ADDR_W / BITS  data address / write data.
REQ-020 o_dack / o_drdata  out  1 / BITS  data-access done pulse / read result.

Function
REQ-021 The state machine SHALL have two states: FETCH (memory port free for instruction read) and HOLD (o_valid high, awaiting i_ready).
REQ-022 The memory port SHALL be arbitrated per cycle in this priority order: i_dreq first, then an instruction fetch in FETCH; o_mem_rw SHALL be high only in a cycle where i_dreq and i_dwe are both high.
REQ-023 When i_dreq is high in any state, the block SHALL drive o_mem_addr=i_daddr and o_mem_data=i_dwdata, then on the next edge pulse o_dack for one cycle and register o_drdata=i_mem_data (reads only; o_drdata unchanged on writes).
REQ-024 In FETCH with i_dreq low and i_jmp low, the block SHALL drive o_mem_addr=pc and, on the edge, latch the instruction register from i_mem_data, set o_pc=pc, increment pc modulo 2^ADDR_W (0xFF wraps to 0x00), set o_valid=1, and go to HOLD.
REQ-025 In FETCH with i_dreq high, the fetch SHALL stall: pc unchanged, state stays FETCH.
REQ-026 In HOLD, when i_ready is high, o_valid SHALL clear on the next edge and the state SHALL return to FETCH; the peak rate is one instruction per two cycles.
REQ-027 While in HOLD with i_ready low, o_op, o_v, o_imm and o_pc SHALL stay stable.
REQ-028 When i_jmp is high in either state, the block SHALL load pc=i_jmp_addr, clear o_valid and go to FETCH on the next edge; the jump overrides i_ready and any fetch in that cycle.
REQ-029 When i_jmp and i_dreq are high together, both SHALL be serviced in the same cycle.
REQ-030 o_op, o_v and o_imm SHALL be pure field slices of the instruction register.

Reset
REQ-031 Assertion of i_rst_n low SHALL immediately set pc=0, state=FETCH, instruction register=0, o_pc=0, o_valid=0, o_dack=0 and o_drdata=0, aborting any fetch or data access in flight.
REQ-032 During reset, o_mem_rw SHALL be 0 and o_mem_addr SHALL be 0.
REQ-033 The first fetch SHALL occur on the first rising edge after deassertion and read address 0x00.

Structure
REQ-034 The shared package cpu_pkg SHALL hold BITS, ADDR_W, the OP/V/DATA field bit positions and the FETCH/HOLD state enum type.
REQ-035 The block SHALL contain no sub-module; it SHALL connect to the memory instance at the top level through the o_mem_*/i_mem_data ports.

Verification
REQ-036 Memory loaded with word0=0x0081 and word1=0x0100, reset released, i_ready=1 -> o_valid pulses with op=0, v=0, imm=0x81, o_pc=0x00, then op=0, v=1, imm=0x00, o_pc=0x01, in alternating cycles.
REQ-037 Hold i_ready=0 for 5 cycles after the first fetch -> o_valid stays high, outputs remain 0x0081/o_pc=0x00, and there is no second fetch (pc=0x01).
REQ-038 Set pc to 0xFF via i_jmp with i_jmp_addr=0xFF, accept one instruction -> next fetch address is 0x00.
REQ-039 Write: i_dreq=1, i_dwe=1, i_daddr=0x10, i_dwdata=0xBEEF, one cycle -> o_mem_rw high that cycle, o_dack next cycle; a read of 0x10 then gives o_drdata=0xBEEF; a concurrent fetch stalls one cycle.
REQ-040 Assert i_jmp (addr 0x20) in HOLD with i_ready=1 -> o_valid drops, the next instruction has o_pc=0x20, and the held instruction is discarded.
REQ-041 Pull i_rst_n low mid-HOLD, asynchronously to the clock -> o_valid=0 and pc=0 immediately; after release the first fetch reads 0x00.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: word/address widths, instruction field positions, fetch FSM states.
package cpu_pkg;
  localparam int BITS    = 16;
  localparam int ADDR_W  = 8;

  localparam int OP_HI   = 15;
  localparam int OP_LO   = 9;
  localparam int V_BIT   = 8;
  localparam int DATA_HI = 7;
  localparam int DATA_LO = 0;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch sharing one memory port with execute data accesses; data access wins the port.
// Fetch to o_valid is one edge; an instruction is held until i_ready, so peak rate is one per two cycles.
module fetch_unit #(
  parameter int BITS   = cpu_pkg::BITS,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_mem_rw,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [BITS-1:0]   o_mem_data,
  input  logic [BITS-1:0]   i_mem_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [6:0]        o_op,
  output logic              o_v,
  output logic [7:0]        o_imm,
  output logic [ADDR_W-1:0] o_pc,
  input  logic              i_jmp,
  input  logic [ADDR_W-1:0] i_jmp_addr,
  input  logic              i_dreq,
  input  logic              i_dwe,
  input  logic [ADDR_W-1:0] i_daddr,
  input  logic [BITS-1:0]   i_dwdata,
  output logic              o_dack,
  output logic [BITS-1:0]   o_drdata
);
  import cpu_pkg::*;

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [BITS-1:0]   ir;
  logic              fetch_go;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= FETCH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_jmp) begin
      state_nxt = FETCH;
    end else begin
      case (state)
        FETCH:   if (!i_dreq) state_nxt = HOLD;
        HOLD:    if (i_ready) state_nxt = FETCH;
        default: state_nxt = FETCH;
      endcase
    end
  end

  // Port is forced idle at address 0 while reset is asserted, whatever execute requests.
  always_comb begin
    fetch_go   = (state == FETCH) && !i_dreq && !i_jmp;
    o_valid    = (state == HOLD);
    o_mem_rw   = i_rst_n && i_dreq && i_dwe;
    o_mem_data = i_dwdata;
    o_mem_addr = '0;
    if (i_rst_n) o_mem_addr = i_dreq ? i_daddr : pc;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc   <= '0;
      ir   <= '0;
      o_pc <= '0;
    end else if (i_jmp) begin
      pc <= i_jmp_addr;
    end else if (fetch_go) begin
      ir   <= i_mem_data;
      o_pc <= pc;
      pc   <= pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dack   <= 1'b0;
      o_drdata <= '0;
    end else begin
      o_dack <= i_dreq;
      if (i_dreq && !i_dwe) o_drdata <= i_mem_data;
    end
  end

  assign o_op  = ir[OP_HI:OP_LO];
  assign o_v   = ir[V_BIT];
  assign o_imm = ir[DATA_HI:DATA_LO];
endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit against a transaction-level model with its own memory copy.
module tb_fetch_unit;
  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        o_mem_rw;
  logic [7:0]  o_mem_addr;
  logic [15:0] o_mem_data;
  logic [15:0] i_mem_data;
  logic        o_valid;
  logic        i_ready;
  logic [6:0]  o_op;
  logic        o_v;
  logic [7:0]  o_imm;
  logic [7:0]  o_pc;
  logic        i_jmp;
  logic [7:0]  i_jmp_addr;
  logic        i_dreq;
  logic        i_dwe;
  logic [7:0]  i_daddr;
  logic [15:0] i_dwdata;
  logic        o_dack;
  logic [15:0] o_drdata;

  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: an instruction is either pending at the decoder or not; pc is the next word to fetch.
  logic [7:0]  m_pc;
  logic        m_valid;
  logic [15:0] m_instr;
  logic [7:0]  m_ipc;
  logic        m_dack;
  logic [15:0] m_drdata;
  logic [7:0]  last_fetch_addr;
  logic        last_rw;

  always #5 i_clk = ~i_clk;

  assign i_mem_data = mem[o_mem_addr];

  fetch_unit #(.BITS(16), .ADDR_W(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_mem_rw(o_mem_rw), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .i_mem_data(i_mem_data),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_op(o_op), .o_v(o_v), .o_imm(o_imm), .o_pc(o_pc),
    .i_jmp(i_jmp), .i_jmp_addr(i_jmp_addr),
    .i_dreq(i_dreq), .i_dwe(i_dwe), .i_daddr(i_daddr), .i_dwdata(i_dwdata),
    .o_dack(o_dack), .o_drdata(o_drdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_valid = 1'b0; m_instr = 16'h0; m_ipc = 8'h00;
    m_dack = 1'b0; m_drdata = 16'h0;
  endtask

  // One clock cycle: drive at negedge, check the port combinationally, advance model, check registers.
  task automatic step(input logic dreq, input logic dwe, input logic [7:0] daddr, input logic [15:0] dwdata,
                      input logic jmp, input logic [7:0] jaddr, input logic rdy);
    logic        fetching;
    logic        wr;
    logic [7:0]  wa;
    logic [15:0] wd;
    i_dreq = dreq; i_dwe = dwe; i_daddr = daddr; i_dwdata = dwdata;
    i_jmp = jmp; i_jmp_addr = jaddr; i_ready = rdy;
    #1;
    fetching = !m_valid && !dreq && !jmp;
    last_rw = o_mem_rw;
    check_eq("mem_rw", o_mem_rw, dreq & dwe);
    if (dreq) begin
      check_eq("data_addr", o_mem_addr, daddr);
      check_eq("data_wdata", o_mem_data, dwdata);
    end else if (fetching) begin
      check_eq("fetch_addr", o_mem_addr, m_pc);
      last_fetch_addr = o_mem_addr;
    end
    wr = o_mem_rw; wa = o_mem_addr; wd = o_mem_data;

    m_dack = dreq;
    if (dreq && !dwe) m_drdata = ref_mem[daddr];
    if (dreq && dwe) ref_mem[daddr] = dwdata;
    if (jmp) begin
      m_pc = jaddr; m_valid = 1'b0;
    end else if (m_valid) begin
      if (rdy) m_valid = 1'b0;
    end else if (!dreq) begin
      m_instr = ref_mem[m_pc]; m_ipc = m_pc; m_pc = m_pc + 8'd1; m_valid = 1'b1;
    end

    @(posedge i_clk);
    if (wr) mem[wa] = wd;
    @(negedge i_clk);
    check_eq("valid", o_valid, m_valid);
    check_eq("dack", o_dack, m_dack);
    check_eq("drdata", o_drdata, m_drdata);
    if (m_valid) begin
      check_eq("op", o_op, m_instr[15:9]);
      check_eq("v", o_v, m_instr[8]);
      check_eq("imm", o_imm, m_instr[7:0]);
      check_eq("pc", o_pc, m_ipc);
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 8'h00, rdy);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_ready = 1'b0; i_jmp = 1'b0; i_jmp_addr = 8'h00;
    i_dreq = 1'b1; i_dwe = 1'b1; i_daddr = 8'h55; i_dwdata = 16'h1234;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[0] = 16'h0081; ref_mem[0] = 16'h0081;
    mem[1] = 16'h0100; ref_mem[1] = 16'h0100;
    last_fetch_addr = 8'hAA;
    last_rw = 1'b0;
    model_reset();

    repeat (2) @(negedge i_clk);
    check_eq("rst_valid", o_valid, 1'b0);
    check_eq("rst_pc", o_pc, 8'h00);
    check_eq("rst_dack", o_dack, 1'b0);
    check_eq("rst_drdata", o_drdata, 16'h0);
    check_eq("rst_mem_rw", o_mem_rw, 1'b0);
    check_eq("rst_mem_addr", o_mem_addr, 8'h00);
    i_dreq = 1'b0; i_dwe = 1'b0;
    i_rst_n = 1'b1;

    // Two back-to-back instructions with the decoder always ready.
    idle(1'b1);
    check_eq("i0_fields", {o_valid, o_op, o_v, o_imm, o_pc}, {1'b1, 7'h00, 1'b0, 8'h81, 8'h00});
    idle(1'b1);
    check_eq("i0_drop", o_valid, 1'b0);
    idle(1'b1);
    check_eq("i1_fields", {o_valid, o_op, o_v, o_imm, o_pc}, {1'b1, 7'h00, 1'b1, 8'h00, 8'h01});

    // Stall at the decoder for five cycles.
    step(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 8'h00, 1'b0);
    idle(1'b0);
    for (int k = 0; k < 5; k++) begin
      idle(1'b0);
      check_eq("hold_fields", {o_valid, o_op, o_v, o_imm, o_pc}, {1'b1, 7'h00, 1'b0, 8'h81, 8'h00});
    end
    idle(1'b1);
    idle(1'b0);
    check_eq("hold_next_fetch", last_fetch_addr, 8'h01);

    // pc wrap from 0xFF.
    step(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 8'hFF, 1'b0);
    idle(1'b0);
    check_eq("wrap_ff_fetch", last_fetch_addr, 8'hFF);
    check_eq("wrap_ff_pc", o_pc, 8'hFF);
    idle(1'b1);
    idle(1'b0);
    check_eq("wrap_00_fetch", last_fetch_addr, 8'h00);

    // Data write then read back, stalling the fetch.
    idle(1'b1);
    step(1'b1, 1'b1, 8'h10, 16'hBEEF, 1'b0, 8'h00, 1'b0);
    check_eq("wr_strobe", last_rw, 1'b1);
    check_eq("wr_ack_stall", {o_dack, o_valid}, {1'b1, 1'b0});
    step(1'b1, 1'b0, 8'h10, 16'h0, 1'b0, 8'h00, 1'b0);
    check_eq("rd_beef", o_drdata, 16'hBEEF);
    idle(1'b0);
    check_eq("stall_fetch_addr", last_fetch_addr, 8'h01);

    // Jump while holding with the decoder ready discards the held instruction.
    step(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 8'h20, 1'b1);
    check_eq("jmp_drop", o_valid, 1'b0);
    idle(1'b0);
    check_eq("jmp_target_pc", {o_valid, o_pc}, {1'b1, 8'h20});

    // Asynchronous reset mid-hold.
    #2;
    i_rst_n = 1'b0; i_dreq = 1'b1; i_dwe = 1'b1; i_daddr = 8'h33;
    #1;
    check_eq("arst_valid", o_valid, 1'b0);
    check_eq("arst_pc", o_pc, 8'h00);
    check_eq("arst_mem_rw", o_mem_rw, 1'b0);
    check_eq("arst_mem_addr", o_mem_addr, 8'h00);
    @(negedge i_clk);
    @(negedge i_clk);
    i_dreq = 1'b0; i_dwe = 1'b0;
    i_rst_n = 1'b1;
    model_reset();
    idle(1'b0);
    check_eq("arst_first_fetch", last_fetch_addr, 8'h00);

    for (int n = 0; n < 500; n++) begin
      step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)),
           16'($urandom), $urandom_range(0, 9) == 0, 8'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
